// File: rtl/tick_sched_pkg.sv
// Shared types and helpers for the tick delay scheduler.
package tick_sched_pkg;

    typedef enum logic {IDLE, COUNT} sched_state_e;

    // Counter load value so that the tick lands exactly max(d,1) cycles after accept.
    function automatic int unsigned clamp_delay(input int unsigned d);
        return (d == 0) ? 0 : d - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    input  logic            enable_i,
    output logic [N-1:0]    grant_o,
    output logic [IdxW-1:0] grant_idx_o,
    output logic            any_o
);

    always_comb begin
        logic found;
        found       = 1'b0;
        grant_o     = '0;
        grant_idx_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned k;
            k = (32'(ptr_i) + i) % N;
            if (enable_i && req_i[k] && !found) begin
                found       = 1'b1;
                grant_o[k]  = 1'b1;
                grant_idx_o = IdxW'(k);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/tick_delay_scheduler.sv
// One shared delay timer serving NUM_REQ requesters; emits a tagged one-cycle tick
// max(D,1) cycles after each accepted request.
module tick_delay_scheduler
    import tick_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DELAY_W = 9,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*DELAY_W-1:0] req_delay_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic                       cancel_i,
    output logic                       busy_o,
    output logic                       tick_o,
    output logic [ID_W-1:0]            tick_id_o
);

    sched_state_e        state_q, state_d;
    logic [DELAY_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic                fire;
    logic                accept_win;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_any;
    logic [DELAY_W-1:0]  sel_delay;

    assign fire = (state_q == COUNT) && (cnt_q == '0);
    // Reset gating keeps req_ready_o low while the block is held in reset.
    assign accept_win = reset_ni && ((state_q == IDLE) || (fire && !cancel_i));

    rr_arbiter #(
        .N    (NUM_REQ),
        .IdxW (ID_W)
    ) u_arb (
        .req_i       (req_valid_i),
        .ptr_i       (rr_ptr_q),
        .enable_i    (accept_win),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_o       (grant_any)
    );

    assign sel_delay = req_delay_i[32'(grant_idx) * DELAY_W +: DELAY_W];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            state_d  = COUNT;
            cnt_d    = DELAY_W'(clamp_delay(32'(sel_delay)));
            id_d     = grant_idx;
            rr_ptr_d = ID_W'((32'(grant_idx) + 1) % NUM_REQ);
        end else if (state_q == COUNT) begin
            if (fire || cancel_i) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            id_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign req_ready_o = grant;
    assign busy_o      = (state_q == COUNT);
    assign tick_o      = fire;
    assign tick_id_o   = id_q;

endmodule

// File: tb/tb_tick_delay_scheduler.sv
// Directed plus randomized bench for tick_delay_scheduler using a timestamp-based model.
module tb_tick_delay_scheduler;

    localparam int N  = 4;
    localparam int DW = 9;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    valid;
    logic [N*DW-1:0] delay;
    logic            cancel;
    logic [N-1:0]    ready;
    logic            busy;
    logic            tick;
    logic [IW-1:0]   tick_id;

    tick_delay_scheduler #(
        .NUM_REQ (N),
        .DELAY_W (DW)
    ) dut (
        .clk_i       (clk),
        .reset_ni    (rst_n),
        .req_valid_i (valid),
        .req_delay_i (delay),
        .req_ready_o (ready),
        .cancel_i    (cancel),
        .busy_o      (busy),
        .tick_o      (tick),
        .tick_id_o   (tick_id)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int now   = 0;

    // Model: a pending tick scheduled at an absolute cycle number.
    bit pend;
    int fire_t;
    int last_id;
    int rr;

    int tick_t[$];
    int tick_i[$];
    logic [N-1:0] last_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, now);
        end
    endtask

    task automatic model_reset();
        pend    = 1'b0;
        fire_t  = 0;
        last_id = 0;
        rr      = 0;
    endtask

    task automatic set_req(input int k, input logic v, input int d);
        valid[k]          = v;
        delay[k*DW +: DW] = DW'(d);
    endtask

    task automatic cycle();
        int           g;
        int           d;
        logic [N-1:0] er;
        logic         et;
        bit           win;
        g = -1;
        @(negedge clk);
        et  = pend && (fire_t == now);
        win = (!pend) || (et && !cancel);
        if (win) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (rr + i) % N;
                if (valid[k] && g < 0) g = k;
            end
        end
        er = (g >= 0) ? (N'(1) << g) : '0;
        check("ready", 32'(ready), 32'(er));
        check("tick", 32'(tick), 32'(et));
        check("busy", 32'(busy), 32'(pend));
        check("tick_id", 32'(tick_id), 32'(last_id));
        last_ready = ready;
        if (tick) begin
            tick_t.push_back(now);
            tick_i.push_back(int'(tick_id));
        end
        if (g >= 0) begin
            d       = int'(delay[g*DW +: DW]);
            pend    = 1'b1;
            fire_t  = now + ((d == 0) ? 1 : d);
            last_id = g;
            rr      = (g + 1) % N;
        end else if (pend && (et || cancel)) begin
            pend = 1'b0;
        end
        @(posedge clk);
        #1;
        // Requester withdraws only after its handshake edge.
        if (g >= 0) valid[g] = 1'b0;
        now++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_ticks();
        tick_t.delete();
        tick_i.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        model_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int a;
    int d_list[3];

    initial begin
        rst_n  = 1'b0;
        valid  = '0;
        delay  = '0;
        cancel = 1'b0;
        model_reset();
        #12;
        check("rst_ready", 32'(ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_id", 32'(tick_id), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic D=100 latency
        clear_ticks();
        set_req(0, 1'b1, 100);
        a = now;
        cycle();
        run(105);
        check("t1_count", 32'(tick_t.size()), 1);
        if (tick_t.size() == 1) begin
            check("t1_lat", 32'(tick_t[0] - a), 100);
            check("t1_id", 32'(tick_i[0]), 0);
        end

        // D=0, D=1, D=max
        d_list = '{0, 1, 511};
        foreach (d_list[j]) begin
            clear_ticks();
            set_req(1, 1'b1, d_list[j]);
            a = now;
            cycle();
            run((d_list[j] == 0 ? 1 : d_list[j]) + 3);
            check("t2_count", 32'(tick_t.size()), 1);
            if (tick_t.size() == 1)
                check("t2_lat", 32'(tick_t[0] - a), (d_list[j] == 0) ? 1 : d_list[j]);
        end

        // Round robin from reset
        do_reset();
        clear_ticks();
        set_req(0, 1'b1, 5);
        set_req(2, 1'b1, 5);
        a = now;
        run(14);
        check("t3_count", 32'(tick_t.size()), 2);
        if (tick_t.size() == 2) begin
            check("t3_t0", 32'(tick_t[0] - a), 5);
            check("t3_id0", 32'(tick_i[0]), 0);
            check("t3_t1", 32'(tick_t[1] - a), 10);
            check("t3_id1", 32'(tick_i[1]), 2);
        end
        set_req(1, 1'b1, 5);
        set_req(3, 1'b1, 5);
        cycle();
        check("t3_rr_grant", 32'(last_ready), 32'h8);
        run(12);

        // Back-to-back handoff in the fire cycle
        clear_ticks();
        set_req(1, 1'b1, 3);
        a = now;
        cycle();
        set_req(2, 1'b1, 4);
        run(10);
        check("t4_count", 32'(tick_t.size()), 2);
        if (tick_t.size() == 2) begin
            check("t4_t0", 32'(tick_t[0] - a), 3);
            check("t4_id0", 32'(tick_i[0]), 1);
            check("t4_t1", 32'(tick_t[1] - a), 7);
            check("t4_id1", 32'(tick_i[1]), 2);
        end

        // Cancel mid-count, then cancel in the fire cycle
        clear_ticks();
        set_req(0, 1'b1, 50);
        cycle();
        run(19);
        cancel = 1'b1;
        cycle();
        cancel = 1'b0;
        run(40);
        check("t5_no_tick", 32'(tick_t.size()), 0);
        set_req(3, 1'b1, 3);
        a = now;
        cycle();
        set_req(0, 1'b1, 7);
        run(2);
        cancel = 1'b1;
        cycle();
        cancel = 1'b0;
        check("t5_fire_ready", 32'(last_ready), 0);
        cycle();
        check("t5_next_grant", 32'(last_ready), 32'h1);
        run(10);
        check("t5_count", 32'(tick_t.size()), 2);
        if (tick_t.size() >= 1) begin
            check("t5_t0", 32'(tick_t[0] - a), 3);
            check("t5_id0", 32'(tick_i[0]), 3);
        end

        // Asynchronous reset mid-count
        set_req(1, 1'b1, 50);
        cycle();
        run(10);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(busy), 0);
        check("t6_tick", 32'(tick), 0);
        check("t6_ready", 32'(ready), 0);
        check("t6_id", 32'(tick_id), 0);
        model_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_ticks();
        run(60);
        check("t6_no_tick", 32'(tick_t.size()), 0);
        set_req(0, 1'b1, 2);
        set_req(1, 1'b1, 2);
        cycle();
        check("t6_rr_zero", 32'(last_ready), 32'h1);
        run(8);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!valid[k] && ($urandom_range(3) == 0))
                    set_req(k, 1'b1, ($urandom_range(15) == 0) ? $urandom_range(511)
                                                              : $urandom_range(8));
                else if (valid[k] && ($urandom_range(15) == 0))
                    valid[k] = 1'b0;
            end
            cancel = ($urandom_range(19) == 0);
            cycle();
        end
        cancel = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
